// File: rtl/sprite_pixel_reader_if.sv
// Sprite ROM read port: registered address/strobe out, palette index data back.
interface sprite_pixel_reader_if #(
   parameter int unsigned IDX_W = 4
);
   logic [20:0]      rom_addr;
   logic             rom_rd;
   logic [IDX_W-1:0] rom_data;

   modport master (
      output rom_addr,
      output rom_rd,
      input  rom_data
   );

   modport slave (
      input  rom_addr,
      input  rom_rd,
      output rom_data
   );
endinterface

// File: rtl/sprite_pixel_reader.sv
// Sprite ROM reader: resolves transparency against the background index, keeps DrawX/DrawY
// aligned with ROM latency, counts opaque pixels per frame and flags bad sprite addresses.
module sprite_pixel_reader #(
   parameter int unsigned ROM_LATENCY  = 2,
   parameter int unsigned SPRITE_DEPTH = 101240,
   parameter int unsigned IDX_W        = 4
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  playerOn,
   input  logic [20:0]           spriteAddress,
   input  logic [9:0]            DrawX,
   input  logic [9:0]            DrawY,
   input  logic [IDX_W-1:0]      bgIndex,
   input  logic                  errClear,
   sprite_pixel_reader_if.master rom,
   output logic [IDX_W-1:0]      pixelIndex,
   output logic [9:0]            pixelX,
   output logic [9:0]            pixelY,
   output logic                  pixelSprite,
   output logic [16:0]           opaqueCount,
   output logic                  addrErr
);
   localparam logic [16:0] COUNT_MAX = '1;

   logic                   inRange;
   logic                   reqHit;
   logic                   reqErr;

   // Stage 0 is the input register; the last stage lines up with rom_data.
   logic [ROM_LATENCY-1:0] hitPipe;
   logic [IDX_W-1:0]       bgPipe [ROM_LATENCY];
   logic [9:0]             xPipe  [ROM_LATENCY];
   logic [9:0]             yPipe  [ROM_LATENCY];

   logic                   spriteHit;
   logic [IDX_W-1:0]       nextIndex;
   logic                   frameStart;
   logic [16:0]            accCount;
   logic [16:0]            accNext;

   always_comb begin
      inRange = {11'd0, spriteAddress} < SPRITE_DEPTH;
      reqHit  = playerOn & inRange;
      reqErr  = playerOn & ~inRange;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rom.rom_rd   <= 1'b0;
         rom.rom_addr <= '0;
         hitPipe      <= '0;
         for (int i = 0; i < ROM_LATENCY; i++) begin
            bgPipe[i] <= '0;
            xPipe[i]  <= '0;
            yPipe[i]  <= '0;
         end
      end else begin
         rom.rom_rd <= reqHit;
         if (reqHit) begin
            rom.rom_addr <= spriteAddress;
         end
         hitPipe[0] <= reqHit;
         bgPipe[0]  <= bgIndex;
         xPipe[0]   <= DrawX;
         yPipe[0]   <= DrawY;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            hitPipe[i] <= hitPipe[i-1];
            bgPipe[i]  <= bgPipe[i-1];
            xPipe[i]   <= xPipe[i-1];
            yPipe[i]   <= yPipe[i-1];
         end
      end
   end

   // Without a hit the ROM word is stale, so it must not influence the result.
   always_comb begin
      spriteHit = hitPipe[ROM_LATENCY-1] & (rom.rom_data != '0);
      nextIndex = spriteHit ? rom.rom_data : bgPipe[ROM_LATENCY-1];
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pixelIndex  <= '0;
         pixelSprite <= 1'b0;
         pixelX      <= '0;
         pixelY      <= '0;
      end else begin
         pixelIndex  <= nextIndex;
         pixelSprite <= spriteHit;
         pixelX      <= xPipe[ROM_LATENCY-1];
         pixelY      <= yPipe[ROM_LATENCY-1];
      end
   end

   // The (0,0) pixel belongs to the new frame, so it seeds the accumulator.
   always_comb begin
      frameStart = (pixelX == '0) && (pixelY == '0);
      if (frameStart) begin
         accNext = {16'd0, pixelSprite};
      end else if (pixelSprite && (accCount != COUNT_MAX)) begin
         accNext = accCount + 17'd1;
      end else begin
         accNext = accCount;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         accCount    <= '0;
         opaqueCount <= '0;
      end else begin
         accCount <= accNext;
         if (frameStart) begin
            opaqueCount <= accCount;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         addrErr <= 1'b0;
      end else if (reqErr) begin
         addrErr <= 1'b1;
      end else if (errClear) begin
         addrErr <= 1'b0;
      end
   end
endmodule
